// File: rtl/data_mem_burst.sv
// ---------------------------------------------------------------------------
// data_mem_burst
//
// Backing data memory placed directly below the write-through cache
// controller. It accepts one request at a time over a valid/ready port:
//   * single-word writes (write-through stores), committed after LATENCY
//     idle cycles with a one-cycle wr_done pulse;
//   * whole-block reads (line fills), returned as WORDS_PER_BLOCK contiguous
//     beats after LATENCY idle cycles, critical word first, wrapping inside
//     the block.
// The beat counter is internal, so the requester only supplies an address.
//
// Parameters
//   ADDR_W          word-address width, array depth 2**ADDR_W
//   WIDTH           data word width
//   WORDS_PER_BLOCK words per block, power of two, 2..16
//   LATENCY         idle cycles between acceptance and first data/commit, 0..15
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  block can accept a request (IDLE only)
//   req_write  1 = single-word write, 0 = block read
//   req_addr   word address (low offset bits pick the critical word on reads)
//   req_wdata  write data
//   rd_valid   read beat valid
//   rd_data    read beat data, 0 when rd_valid = 0
//   rd_idx     word offset within the block of the current beat
//   rd_last    final beat of the burst
//   wr_done    one-cycle pulse, write committed at the end of this cycle
// ---------------------------------------------------------------------------
module data_mem_burst #(
    parameter int ADDR_W          = 10,
    parameter int WIDTH           = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int LATENCY         = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [ADDR_W-1:0]                  req_addr,
    input  logic [WIDTH-1:0]                   req_wdata,
    output logic                               rd_valid,
    output logic [WIDTH-1:0]                   rd_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] rd_idx,
    output logic                               rd_last,
    output logic                               wr_done
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LAT_W = 4;

    // The WAIT state is skipped entirely when there is no access latency.
    localparam bit                HAS_WAIT  = (LATENCY > 0);
    localparam logic [LAT_W-1:0]  LAT_LAST  = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;
    localparam logic [OFF_W-1:0]  BEAT_LAST = OFF_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Storage (intentionally not reset)
    logic [WIDTH-1:0]  mem_r [DEPTH];

    // Control state
    state_t            state_r;
    state_t            state_s;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic [LAT_W-1:0]  lat_cnt_s;
    logic [OFF_W-1:0]  beat_r;
    logic [OFF_W-1:0]  beat_s;

    // Captured request
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [WIDTH-1:0]  wdata_r;
    logic [WIDTH-1:0]  wdata_s;
    logic              write_r;
    logic              write_s;

    // Look-ahead beat address and registered outputs
    logic              accept_s;
    logic [OFF_W-1:0]  rd_idx_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [WIDTH-1:0]  mem_q_r;
    logic              req_ready_r;
    logic              rd_valid_r;
    logic [OFF_W-1:0]  rd_idx_r;
    logic              rd_last_r;
    logic              wr_done_r;

    // Next-state, request capture and beat/latency counter logic
    always_comb begin
        state_s   = state_r;
        lat_cnt_s = lat_cnt_r;
        beat_s    = beat_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        write_s   = write_r;

        // req_ready_r is only ever high in IDLE, so this is also the IDLE test.
        accept_s  = req_valid & req_ready_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    addr_s    = req_addr;
                    wdata_s   = req_wdata;
                    write_s   = req_write;
                    lat_cnt_s = '0;
                    beat_s    = '0;
                    if (HAS_WAIT) begin
                        state_s = WAIT;
                    end else if (req_write) begin
                        state_s = WRITE;
                    end else begin
                        state_s = BURST;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            WAIT: begin
                // WAIT occupies exactly LATENCY cycles (counter 0..LATENCY-1).
                if (lat_cnt_r == LAT_LAST) begin
                    lat_cnt_s = '0;
                    beat_s    = '0;
                    if (write_r) begin
                        state_s = WRITE;
                    end else begin
                        state_s = BURST;
                    end
                end else begin
                    lat_cnt_s = lat_cnt_r + LAT_W'(1);
                end
            end

            BURST: begin
                if (beat_r == BEAT_LAST) begin
                    beat_s  = '0;
                    state_s = IDLE;
                end else begin
                    beat_s  = beat_r + OFF_W'(1);
                end
            end

            WRITE: begin
                state_s = IDLE;
            end

            default: begin
                state_s   = IDLE;
                lat_cnt_s = '0;
                beat_s    = '0;
            end
        endcase

        // Offset arithmetic is done in OFF_W bits, so the wrap-around stays
        // inside the block and never carries into the block base.
        rd_idx_s  = addr_s[OFF_W-1:0] + beat_s;
        rd_addr_s = {addr_s[ADDR_W-1:OFF_W], rd_idx_s};
    end

    // State, captured request and registered output flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            lat_cnt_r   <= '0;
            beat_r      <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            write_r     <= 1'b0;
            req_ready_r <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_idx_r    <= '0;
            rd_last_r   <= 1'b0;
            wr_done_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            lat_cnt_r   <= lat_cnt_s;
            beat_r      <= beat_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            write_r     <= write_s;
            // Outputs are computed from the next state so that they are
            // registered yet line up with the state they describe.
            req_ready_r <= (state_s == IDLE);
            rd_valid_r  <= (state_s == BURST);
            rd_idx_r    <= (state_s == BURST) ? rd_idx_s : '0;
            rd_last_r   <= (state_s == BURST) && (beat_s == BEAT_LAST);
            wr_done_r   <= (state_s == WRITE);
        end
    end

    // Array write port: commit at the edge ending the WRITE cycle unless reset
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == WRITE)) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

    // Array read port: fetch the word for the beat presented next cycle
    always_ff @(posedge clk) begin
        mem_q_r <= mem_r[rd_addr_s];
    end

    assign req_ready = req_ready_r;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_valid_r ? mem_q_r : '0;
    assign rd_idx    = rd_idx_r;
    assign rd_last   = rd_last_r;
    assign wr_done   = wr_done_r;

endmodule

// File: tb/tb_data_mem_burst.sv
module tb_data_mem_burst;

    logic        clk;
    logic        rst_n;

    // DUT A: LATENCY = 2, WORDS_PER_BLOCK = 4
    logic        a_req_valid;
    logic        a_req_ready;
    logic        a_req_write;
    logic [9:0]  a_req_addr;
    logic [31:0] a_req_wdata;
    logic        a_rd_valid;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_idx;
    logic        a_rd_last;
    logic        a_wr_done;

    // DUT B: LATENCY = 0, WORDS_PER_BLOCK = 8
    logic        b_req_valid;
    logic        b_req_ready;
    logic        b_req_write;
    logic [9:0]  b_req_addr;
    logic [31:0] b_req_wdata;
    logic        b_rd_valid;
    logic [31:0] b_rd_data;
    logic [2:0]  b_rd_idx;
    logic        b_rd_last;
    logic        b_wr_done;

    int checks;
    int errors;

    data_mem_burst #(.ADDR_W(10), .WIDTH(32), .WORDS_PER_BLOCK(4), .LATENCY(2)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_write (a_req_write),
        .req_addr  (a_req_addr),
        .req_wdata (a_req_wdata),
        .rd_valid  (a_rd_valid),
        .rd_data   (a_rd_data),
        .rd_idx    (a_rd_idx),
        .rd_last   (a_rd_last),
        .wr_done   (a_wr_done)
    );

    data_mem_burst #(.ADDR_W(10), .WIDTH(32), .WORDS_PER_BLOCK(8), .LATENCY(0)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_write (b_req_write),
        .req_addr  (b_req_addr),
        .req_wdata (b_req_wdata),
        .rd_valid  (b_rd_valid),
        .rd_data   (b_rd_data),
        .rd_idx    (b_rd_idx),
        .rd_last   (b_rd_last),
        .wr_done   (b_wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; afterwards we are inside the following cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a request on A, wait for ready, pass the acceptance edge
    task automatic issue_a(input logic wr, input logic [9:0] addr, input logic [31:0] data);
        int n;
        a_req_valid = 1'b1;
        a_req_write = wr;
        a_req_addr  = addr;
        a_req_wdata = data;
        n = 0;
        while (!a_req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("a_ready_wait", 32'(a_req_ready), 32'd1);
        tick();
        a_req_valid = 1'b0;
    endtask

    task automatic write_a(input logic [9:0] addr, input logic [31:0] data);
        int n;
        issue_a(1'b1, addr, data);
        chk("a_wr_busy", 32'(a_req_ready), 32'd0);
        n = 0;
        while (!a_wr_done && n < 20) begin
            tick();
            n++;
        end
        chk("a_wr_latency", 32'(n), 32'd2);
        tick();
        chk("a_wr_pulse", 32'(a_wr_done), 32'd0);
        chk("a_wr_ready_back", 32'(a_req_ready), 32'd1);
    endtask

    task automatic read_a(input logic [9:0] addr, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
        int n;
        logic [31:0] ex [4];
        logic [1:0]  ei;
        ex = '{e0, e1, e2, e3};
        issue_a(1'b0, addr, 32'h0);
        n = 0;
        while (!a_rd_valid && n < 20) begin
            tick();
            n++;
        end
        chk("a_rd_first_cycle", 32'(n), 32'd2);
        for (int k = 0; k < 4; k++) begin
            ei = addr[1:0] + 2'(k);
            chk("a_rd_valid", 32'(a_rd_valid), 32'd1);
            chk("a_rd_data", a_rd_data, ex[k]);
            chk("a_rd_idx", 32'(a_rd_idx), 32'(ei));
            chk("a_rd_last", 32'(a_rd_last), (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("a_rd_end_valid", 32'(a_rd_valid), 32'd0);
        chk("a_rd_end_data", a_rd_data, 32'd0);
        chk("a_rd_end_ready", 32'(a_req_ready), 32'd1);
    endtask

    task automatic write_b(input logic [9:0] addr, input logic [31:0] data);
        int n;
        b_req_valid = 1'b1;
        b_req_write = 1'b1;
        b_req_addr  = addr;
        b_req_wdata = data;
        n = 0;
        while (!b_req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("b_ready_wait", 32'(b_req_ready), 32'd1);
        tick();
        b_req_valid = 1'b0;
        chk("b_wr_done_c0", 32'(b_wr_done), 32'd1);
        tick();
        chk("b_wr_pulse", 32'(b_wr_done), 32'd0);
        chk("b_wr_ready_back", 32'(b_req_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [2:0] eb;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        a_req_valid = 1'b0;
        a_req_write = 1'b0;
        a_req_addr  = 10'h0;
        a_req_wdata = 32'h0;
        b_req_valid = 1'b0;
        b_req_write = 1'b0;
        b_req_addr  = 10'h0;
        b_req_wdata = 32'h0;

        // reset state
        repeat (3) tick();
        chk("rst_ready", 32'(a_req_ready), 32'd0);
        chk("rst_rd_valid", 32'(a_rd_valid), 32'd0);
        chk("rst_rd_data", a_rd_data, 32'd0);
        chk("rst_rd_idx", 32'(a_rd_idx), 32'd0);
        chk("rst_rd_last", 32'(a_rd_last), 32'd0);
        chk("rst_wr_done", 32'(a_wr_done), 32'd0);
        chk("rst_b_ready", 32'(b_req_ready), 32'd0);

        // release with a write already presented: not accepted at the release edge
        rst_n       = 1'b1;
        a_req_valid = 1'b1;
        a_req_write = 1'b1;
        a_req_addr  = 10'h005;
        a_req_wdata = 32'hDEADBEEF;
        tick();
        chk("rel_ready", 32'(a_req_ready), 32'd1);
        chk("rel_rd_valid", 32'(a_rd_valid), 32'd0);
        chk("rel_wr_done", 32'(a_wr_done), 32'd0);
        write_a(10'h005, 32'hDEADBEEF);

        // critical-word-first wrap
        for (int i = 0; i < 4; i++) write_a(10'h008 + 10'(i), 32'hA0 + 32'(i));
        read_a(10'h00A, 32'hA2, 32'hA3, 32'hA0, 32'hA1);

        // top block, no overflow out of the block
        for (int i = 0; i < 4; i++) write_a(10'h3FC + 10'(i), 32'hB0 + 32'(i));
        read_a(10'h3FF, 32'hB3, 32'hB0, 32'hB1, 32'hB2);

        // read-after-write at the first ready cycle
        for (int i = 0; i < 4; i++) write_a(10'h010 + 10'(i), 32'hC0 + 32'(i));
        write_a(10'h011, 32'h12345678);
        read_a(10'h010, 32'hC0, 32'h12345678, 32'hC2, 32'hC3);

        // reset during beat 1 of a read
        issue_a(1'b0, 10'h008, 32'h0);
        tick();
        tick();
        chk("abort_beat0", a_rd_data, 32'hA0);
        tick();
        chk("abort_beat1", a_rd_data, 32'hA1);
        rst_n = 1'b0;
        tick();
        chk("abort_valid_rst", 32'(a_rd_valid), 32'd0);
        chk("abort_ready_rst", 32'(a_req_ready), 32'd0);
        chk("abort_data_rst", a_rd_data, 32'd0);
        tick();
        chk("abort_valid_rst2", 32'(a_rd_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_ready_rel", 32'(a_req_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_rd_valid) n++;
            tick();
        end
        chk("abort_no_beats", 32'(n), 32'd0);

        // reset during WAIT of a write
        write_a(10'h020, 32'h55AA55AA);
        for (int i = 1; i < 4; i++) write_a(10'h020 + 10'(i), 32'hD0 + 32'(i));
        issue_a(1'b1, 10'h020, 32'hFFFF0000);
        rst_n = 1'b0;
        tick();
        chk("drop_wr_rst", 32'(a_wr_done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("drop_ready_rel", 32'(a_req_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_wr_done) n++;
            tick();
        end
        chk("drop_no_wr_done", 32'(n), 32'd0);
        read_a(10'h020, 32'h55AA55AA, 32'hD1, 32'hD2, 32'hD3);

        // LATENCY = 0, 8-word blocks, req_valid held throughout the burst
        for (int i = 0; i < 8; i++) write_b(10'h040 + 10'(i), 32'hE0 + 32'(i));
        b_req_valid = 1'b1;
        b_req_write = 1'b0;
        b_req_addr  = 10'h043;
        tick();
        for (int k = 0; k < 8; k++) begin
            eb = 3'd3 + 3'(k);
            chk("b_rd_valid", 32'(b_rd_valid), 32'd1);
            chk("b_rd_data", b_rd_data, 32'hE0 + 32'(eb));
            chk("b_rd_idx", 32'(b_rd_idx), 32'(eb));
            chk("b_rd_last", 32'(b_rd_last), (k == 7) ? 32'd1 : 32'd0);
            chk("b_busy_ready", 32'(b_req_ready), 32'd0);
            tick();
        end
        chk("b_end_valid", 32'(b_rd_valid), 32'd0);
        chk("b_end_ready", 32'(b_req_ready), 32'd1);
        b_req_valid = 1'b0;
        tick();
        chk("b_idle_valid", 32'(b_rd_valid), 32'd0);
        chk("b_idle_ready", 32'(b_req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_burst.md
# data_mem_burst

Parametrised backing data memory for the write-through cache controller. It serves single-word write-through stores and whole-block line fills over a valid/ready request port. An internal beat counter drives the transfer, so the cache no longer has to supply one. Line fills are returned critical-word-first with wrap-around, after a configurable access latency. It replaces the fixed 4-word, externally-counted memory and sits directly below the cache controller.

## Interface
- ADDR_W, 10, word-address width; array depth is 2**ADDR_W words
- WIDTH, 32, data word width
- WORDS_PER_BLOCK, 4, words per cache block; power of two, 2..16
- LATENCY, 2, idle cycles between request acceptance and first data or write completion; 0..15
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_write  in  1  1 = single-word write, 0 = block read
- req_addr  in  ADDR_W  word address; for reads, its low log2(WORDS_PER_BLOCK) bits select the critical word
- req_wdata  in  WIDTH  write data
- rd_valid  out  1  read beat valid
- rd_data  out  WIDTH  read beat data; 0 when rd_valid = 0
- rd_idx  out  log2(WORDS_PER_BLOCK)  word offset within the block of the current beat
- rd_last  out  1  final beat of the burst
- wr_done  out  1  one-cycle pulse: write committed to the array

## Operation
- FSM states: IDLE, WAIT, BURST, WRITE.
- IDLE: req_ready = 1. A request is accepted on a rising edge where req_valid & req_ready. On acceptance, req_write, req_addr and req_wdata are captured.
  - The next state is WAIT if LATENCY > 0.
  - Otherwise the next state is BURST for a read, or WRITE for a write.
- WAIT: a latency counter counts LATENCY cycles. It then moves to BURST for a read, or WRITE for a write. req_valid is ignored.
- BURST: emits exactly WORDS_PER_BLOCK beats, one per cycle, with no gaps.
  - Beat k reads word {base, (crit + k) mod WORDS_PER_BLOCK}, where base = req_addr with its offset bits cleared and crit = req_addr offset bits.
  - rd_idx equals that offset. rd_last is high on beat WORDS_PER_BLOCK-1 only.
  - After the last beat the FSM goes to IDLE.
- WRITE: mem[req_addr] <= req_wdata on the edge ending this cycle. wr_done = 1 for this cycle only. The FSM then goes to IDLE.
- The array is not reset; its contents are undefined until written.
- No request queueing: back-to-back requests are separated by at least one IDLE cycle.
- Reset (rst_n = 0 at an edge): state goes to IDLE and all counters clear.
  - A burst in progress is aborted: no further beats are produced.
  - A write in WAIT is dropped and the array is unchanged.
  - A write in WRITE on the reset edge is also dropped.

## Timing
- All outputs are registered, or decoded from registered state.
- Outputs while rst_n = 0 and in the first cycle after release:
  - While rst_n = 0: req_ready = 0, rd_valid = 0, rd_data = 0, rd_idx = 0, rd_last = 0, wr_done = 0.
  - In the first cycle after release: the FSM is in IDLE, so req_ready = 1 and all other outputs remain 0.
- Notation: acceptance edge = E, and cycle n = the cycle following edge E + n.
- Read latency: beat k is valid in cycle LATENCY + k. req_ready is high again in cycle LATENCY + WORDS_PER_BLOCK.
- Write: wr_done is high in cycle LATENCY. The array is updated at the edge ending that cycle. req_ready is high in cycle LATENCY + 1.
- Read-after-write: a read accepted at the earliest allowed edge after wr_done returns the new data. No bypass is needed.
- A request presented while req_ready = 0 is not accepted. The requester must hold req_valid and all request fields until acceptance.

## Test plan
- Reset release, then write 0xDEADBEEF to address 0x005 with LATENCY = 2 (req_valid high in cycle 0). Required: wr_done high exactly 2 cycles after the acceptance edge, req_ready high the following cycle, all outputs 0 during reset.
- Preload words 0x008..0x00B with 0xA0..0xA3, then read address 0x00A. Required: beats A2, A3, A0, A1; rd_idx = 2, 3, 0, 1; rd_last only on the 4th beat; first beat in cycle 2.
- Read address 0x3FF (top block). Required: beats at 0x3FF, 0x3FC, 0x3FD, 0x3FE, with no address overflow outside the block.
- Write 0x12345678 to address 0x011, then read 0x010 at the first cycle req_ready returns. Required: the second beat is 0x12345678 with rd_idx = 1.
- Reset mid-operation:
  - Assert rst_n = 0 during beat 1 of a read. Required: no further rd_valid pulses, and req_ready = 1 in the cycle after release.
  - Assert rst_n = 0 during the WAIT state of a write to 0x020. Required: mem[0x020] is unchanged and wr_done never pulses.
- Rebuild with LATENCY = 0 and WORDS_PER_BLOCK = 8, then read 0x043. Required: 8 contiguous beats starting in cycle 0 with rd_idx 3..7, 0..2, and req_valid ignored while busy.
